// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I load/store path: store-type encodings
// and the byte-enable type used between the store aligner and data memory.
package rv32i_pkg;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    typedef logic [3:0] byte_en_t;

endpackage

// File: rtl/rv32i_store_align.sv
// Turns a store request into per-lane byte enables and lane-replicated write
// data, so the memory can write any lane straight from the matching data byte.
module rv32i_store_align
    import rv32i_pkg::*;
(
    input  logic        cu_store,
    input  logic [1:0]  cu_storetype,
    input  logic [1:0]  addr_low,
    input  logic [31:0] rs2,
    output byte_en_t    byte_en,
    output logic [31:0] wdata
);

    // Reserved storetype and cu_store=0 both fall through to no enabled lanes.
    always_comb begin
        byte_en = '0;
        wdata   = '0;
        if (cu_store) begin
            case (cu_storetype)
                ST_SB: begin
                    byte_en = byte_en_t'(4'b0001 << addr_low);
                    wdata   = {4{rs2[7:0]}};
                end
                ST_SH: begin
                    byte_en = addr_low[1] ? 4'b1100 : 4'b0011;
                    wdata   = {2{rs2[15:0]}};
                end
                ST_SW: begin
                    byte_en = 4'b1111;
                    wdata   = rs2;
                end
                default: begin
                    byte_en = '0;
                    wdata   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rv32i_data_mem.sv
// Word-organised data memory for the single-cycle RV32I core: lane-masked
// stores, synchronous clear on reset, and a combinational full-word read.
module rv32i_data_mem
    import rv32i_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cu_store,
    input  logic [1:0]  cu_storetype,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] rs2,
    output logic [31:0] dmem_out
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] word_idx;
    byte_en_t         byte_en;
    logic [31:0]      wdata;
    logic             unused_addr_bits;

    // Upper address bits are dropped so accesses wrap around the array.
    assign word_idx         = dmem_addr[IDX_W+1:2];
    assign unused_addr_bits = ^dmem_addr[31:IDX_W+2];

    rv32i_store_align u_store_align (
        .cu_store     (cu_store),
        .cu_storetype (cu_storetype),
        .addr_low     (dmem_addr[1:0]),
        .rs2          (rs2),
        .byte_en      (byte_en),
        .wdata        (wdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int lane = 0; lane < 4; lane++) begin
                if (byte_en[lane]) begin
                    mem[word_idx][lane*8 +: 8] <= wdata[lane*8 +: 8];
                end
            end
        end
    end

    assign dmem_out = mem[word_idx];

endmodule

// File: tb/tb_rv32i_data_mem.sv
// Self-checking bench for rv32i_data_mem: directed cases followed by random
// stores checked against a byte-addressed reference memory.
module tb_rv32i_data_mem;

    localparam int DEPTH_WORDS = 1024;
    localparam int MEM_BYTES   = 4 * DEPTH_WORDS;

    logic        clock;
    logic        reset;
    logic        cu_store;
    logic [1:0]  cu_storetype;
    logic [31:0] dmem_addr;
    logic [31:0] rs2;
    logic [31:0] dmem_out;

    int error_count;
    int check_count;

    logic [7:0] model_mem [MEM_BYTES];

    rv32i_data_mem #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
        .clock        (clock),
        .reset        (reset),
        .cu_store     (cu_store),
        .cu_storetype (cu_storetype),
        .dmem_addr    (dmem_addr),
        .rs2          (rs2),
        .dmem_out     (dmem_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, observed, expected);
        end
    endtask

    // Reference: a flat byte memory; stores write whole bytes at aligned byte addresses.
    function automatic void modelStore(input logic [1:0] st, input logic [31:0] addr,
                                       input logic [31:0] data);
        int b;
        b = int'(addr % MEM_BYTES);
        case (st)
            2'd0: model_mem[b] = data[7:0];
            2'd1: begin
                b = b - (b % 2);
                model_mem[b]   = data[7:0];
                model_mem[b+1] = data[15:8];
            end
            2'd2: begin
                b = b - (b % 4);
                for (int k = 0; k < 4; k++) model_mem[b+k] = data[8*k +: 8];
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        int b;
        b = int'(addr % MEM_BYTES);
        b = b - (b % 4);
        return {model_mem[b+3], model_mem[b+2], model_mem[b+1], model_mem[b]};
    endfunction

    function automatic void modelClear();
        for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'h00;
    endfunction

    // One clock cycle: drive on the falling edge, check the pre-edge value, then the post-edge value.
    task automatic applyStimulus(input string tag, input logic rst, input logic st_en,
                                 input logic [1:0] st, input logic [31:0] addr,
                                 input logic [31:0] data);
        @(negedge clock);
        reset        = rst;
        cu_store     = st_en;
        cu_storetype = st;
        dmem_addr    = addr;
        rs2          = data;
        #1;
        checkOutput({tag, "_pre"}, dmem_out, modelRead(addr));
        @(posedge clock);
        if (rst) modelClear();
        else if (st_en) modelStore(st, addr, data);
        #1;
        checkOutput({tag, "_post"}, dmem_out, modelRead(addr));
    endtask

    task automatic readAt(input string tag, input logic [31:0] addr,
                          input logic [31:0] expected);
        @(negedge clock);
        reset     = 1'b0;
        cu_store  = 1'b0;
        dmem_addr = addr;
        rs2       = $urandom;
        #1;
        checkOutput(tag, dmem_out, expected);
    endtask

    initial begin
        logic [31:0] addr;
        logic [1:0]  st;
        logic        st_en;
        logic        rst;
        error_count  = 0;
        check_count  = 0;
        reset        = 1'b1;
        cu_store     = 1'b0;
        cu_storetype = 2'b00;
        dmem_addr    = '0;
        rs2          = '0;
        modelClear();

        repeat (2) @(posedge clock);
        readAt("reset_a0", 32'h0, 32'h0);
        readAt("reset_a4", 32'h4, 32'h0);

        applyStimulus("sw0", 1'b0, 1'b1, 2'b10, 32'h0, 32'hDEADBEEF);
        readAt("sw0_rd", 32'h0, 32'hDEADBEEF);
        readAt("sw0_a4", 32'h4, 32'h0);

        applyStimulus("sb1", 1'b0, 1'b1, 2'b00, 32'h1, 32'h000000AA);
        readAt("sb1_rd", 32'h0, 32'hDEADAAEF);
        applyStimulus("sb3", 1'b0, 1'b1, 2'b00, 32'h3, 32'h00000011);
        readAt("sb3_rd", 32'h0, 32'h11ADAAEF);

        applyStimulus("sh2", 1'b0, 1'b1, 2'b01, 32'h2, 32'h00001234);
        readAt("sh2_rd", 32'h0, 32'h1234AAEF);
        applyStimulus("sh3", 1'b0, 1'b1, 2'b01, 32'h3, 32'h00005678);
        readAt("sh3_rd", 32'h0, 32'h5678AAEF);

        applyStimulus("nostore", 1'b0, 1'b0, 2'b10, 32'h4, 32'hFFFFFFFF);
        readAt("nostore_rd", 32'h4, 32'h0);
        applyStimulus("st11", 1'b0, 1'b1, 2'b11, 32'h0, 32'hFFFFFFFF);
        readAt("st11_rd", 32'h0, 32'h5678AAEF);
        applyStimulus("sw4", 1'b0, 1'b1, 2'b10, 32'h4, 32'hCAFEBABE);
        readAt("sw4_rd", 32'h4, 32'hCAFEBABE);

        readAt("alias_rd", 32'(MEM_BYTES), 32'h5678AAEF);
        applyStimulus("alias_sw", 1'b0, 1'b1, 2'b10, 32'(MEM_BYTES), 32'h0BADF00D);
        readAt("alias_rd0", 32'h0, 32'h0BADF00D);

        applyStimulus("rst_prio", 1'b1, 1'b1, 2'b10, 32'h8, 32'h12345678);
        readAt("rst_prio_a8", 32'h8, 32'h0);
        readAt("rst_prio_a4", 32'h4, 32'h0);
        readAt("rst_prio_a0", 32'h0, 32'h0);

        for (int n = 0; n < 400; n++) begin
            addr  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_F03F);
            st    = 2'($urandom_range(0, 3));
            st_en = ($urandom_range(0, 4) != 0);
            rst   = ($urandom_range(0, 99) == 0);
            applyStimulus("rand", rst, st_en, st, addr, $urandom);
            addr = $urandom & 32'hFFFF_F03F;
            readAt("rand_rd", addr, modelRead(addr));
        end

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
